us_mac_tx_framer: RTL and testbench

US_MAC_TX_FRAMER -- requirements
Module: us_mac_tx_framer

---
 rtl/us_eth_pkg.sv | 48 ++++
 rtl/us_mac_tx_framer.sv | 208 ++++++++++++++++++++
 tb/tb_us_mac_tx_framer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/us_eth_pkg.sv
// Ethernet framing constants, transmit-framer state encoding and byte-lane helpers.
package us_eth_pkg;

    localparam int          ETH_HDR_BYTES       = 14;
    localparam int          ETH_MIN_FRAME_BYTES = 60;
    localparam logic [15:0] ETH_TYPE_ARP        = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4       = 16'h0800;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_BODY = 3'd3,
        ST_TAIL = 3'd4,
        ST_PAD  = 3'd5
    } tx_state_e;

    // Number of valid bytes in a contiguous-from-bit-0 keep vector.
    function automatic logic [3:0] keep_to_count(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    // Contiguous keep vector for n valid bytes (n saturates at 8).
    function automatic logic [7:0] count_to_keep(input logic [3:0] n);
        logic [8:0] t;
        if (n >= 4'd8) begin
            t = 9'h0ff;
        end else begin
            t = (9'd1 << n) - 9'd1;
        end
        return t[7:0];
    endfunction

    // Expands a keep vector into a 64-bit byte mask.
    function automatic logic [63:0] keep_to_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/us_mac_tx_framer.sv
// Ethernet transmit framer: prepends dst MAC, src MAC and EtherType to a 64-bit
// AXI-Stream payload, realigns the payload by 6 bytes, and zero-pads short frames.
module us_mac_tx_framer
    import us_eth_pkg::*;
#(
    parameter bit PAD_EN          = 1'b1,
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
    input  logic        tx_axis_aclk,
    input  logic        tx_axis_areset,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    input  logic [47:0] dst_mac_addr,
    input  logic [47:0] src_mac_addr,
    input  logic [15:0] eth_type,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        frame_busy
);

    localparam logic [16:0] MIN17 = 17'(MIN_FRAME_BYTES);

    tx_state_e   state, state_nxt;
    logic [47:0] dst_q, src_q;
    logic [15:0] type_q;
    logic [47:0] carry_q;
    logic [15:0] count_q;
    logic [2:0]  tail_q;

    logic        out_ready;
    logic [63:0] cur_data;
    logic [3:0]  cur_bytes;
    logic [63:0] hdr0_word;
    logic [47:0] hdr1_low;
    logic [16:0] total;
    logic [16:0] room;
    logic [16:0] count_sum;

    logic        latch_en, load, carry_en, s_ready;
    logic [63:0] ld_data;
    logic [3:0]  ld_bytes, beat_bytes;
    logic        ld_last, beat_final;
    logic [2:0]  tail_nxt;

    // The output register can take a new beat when empty or being drained.
    assign out_ready = !m_axis_tvalid || m_axis_tready;

    // Invalid input lanes are zeroed here so carry and tail bytes are always clean.
    assign cur_bytes = keep_to_count(s_axis_tkeep);
    assign cur_data  = s_axis_tdata & keep_to_mask(s_axis_tkeep);

    // Header words in wire order: byte 0 of a beat is tdata[7:0], MSB of each field first.
    assign hdr0_word = {src_q[39:32], src_q[47:40],
                        dst_q[7:0], dst_q[15:8], dst_q[23:16],
                        dst_q[31:24], dst_q[39:32], dst_q[47:40]};
    assign hdr1_low  = {type_q[7:0], type_q[15:8],
                        src_q[7:0], src_q[15:8], src_q[23:16], src_q[31:24]};

    // Running-count arithmetic used for the padding decision and the count update.
    assign total     = {1'b0, count_q} + {13'b0, beat_bytes};
    assign room      = MIN17 - {1'b0, count_q};
    assign count_sum = {1'b0, count_q} + {13'b0, ld_bytes};

    assign s_axis_tready = s_ready;
    assign frame_busy    = (state != ST_IDLE) || (m_axis_tvalid && m_axis_tlast);

    // Next-state and beat-build logic; padding overrides the final data beat.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        state_nxt  = state;
        latch_en   = 1'b0;
        load       = 1'b0;
        carry_en   = 1'b0;
        s_ready    = 1'b0;
        ld_data    = '0;
        beat_bytes = 4'd0;
        beat_final = 1'b0;
        tail_nxt   = tail_q;
        ld_bytes   = 4'd0;
        ld_last    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    latch_en  = 1'b1;
                    state_nxt = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (out_ready) begin
                    load       = 1'b1;
                    ld_data    = hdr0_word;
                    beat_bytes = 4'd8;
                    state_nxt  = ST_HDR1;
                end
            end
            ST_HDR1, ST_BODY: begin
                s_ready = out_ready;
                if (s_axis_tvalid && out_ready) begin
                    load       = 1'b1;
                    carry_en   = 1'b1;
                    ld_data    = {cur_data[15:0], ((state == ST_HDR1) ? hdr1_low : carry_q)};
                    beat_bytes = 4'd8;
                    state_nxt  = ST_BODY;
                    if (s_axis_tlast) begin
                        if (cur_bytes > 4'd2) begin
                            tail_nxt  = 3'(cur_bytes - 4'd2);
                            state_nxt = ST_TAIL;
                        end else begin
                            beat_bytes = 4'd6 + cur_bytes;
                            beat_final = 1'b1;
                        end
                    end
                end
            end
            ST_TAIL: begin
                if (out_ready) begin
                    load       = 1'b1;
                    ld_data    = {16'h0000, carry_q};
                    beat_bytes = {1'b0, tail_q};
                    beat_final = 1'b1;
                end
            end
            ST_PAD: begin
                if (out_ready) begin
                    load       = 1'b1;
                    beat_final = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        ld_bytes = beat_bytes;
        if (beat_final) begin
            ld_last   = 1'b1;
            state_nxt = ST_IDLE;
            if (PAD_EN && (total < MIN17)) begin
                if (room <= 17'd8) begin
                    ld_bytes = room[3:0];
                end else begin
                    ld_bytes  = 4'd8;
                    ld_last   = 1'b0;
                    state_nxt = ST_PAD;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (tx_axis_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-frame context: latched header fields, 6-byte carry, tail size and byte count.
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            dst_q   <= '0;
            src_q   <= '0;
            type_q  <= '0;
            carry_q <= '0;
            count_q <= '0;
            tail_q  <= '0;
        end else begin
            if (latch_en) begin
                dst_q   <= dst_mac_addr;
                src_q   <= src_mac_addr;
                type_q  <= eth_type;
                count_q <= '0;
            end else if (load) begin
                count_q <= count_sum[16] ? 16'hffff : count_sum[15:0];
            end
            if (carry_en) begin
                carry_q <= cur_data[63:16];
            end
            tail_q <= tail_nxt;
        end
    end

    // Registered output beat; contents are held until the sink accepts them.
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ld_data;
            m_axis_tkeep  <= count_to_keep(ld_bytes);
            m_axis_tlast  <= ld_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_us_mac_tx_framer.sv
// Directed self-checking bench for us_mac_tx_framer (default PAD_EN=1, 60-byte minimum).
module tb_us_mac_tx_framer;
    import us_eth_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [47:0] dst_mac_addr = '0;
    logic [47:0] src_mac_addr = '0;
    logic [15:0] eth_type = '0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        frame_busy;

    always #5 clk = ~clk;

    us_mac_tx_framer dut (
        .tx_axis_aclk   (clk),
        .tx_axis_areset (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .dst_mac_addr   (dst_mac_addr),
        .src_mac_addr   (src_mac_addr),
        .eth_type       (eth_type),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .frame_busy     (frame_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  pay [0:127];
    logic [47:0] exp_dst, exp_src;
    logic [15:0] exp_type;
    logic [7:0]  out_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  keep_q [$];
    logic        last_q [$];
    logic [63:0] data_q [$];
    int          cyc_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one payload frame; empty_last appends a tlast beat with keep 0.
    task automatic send_frame(input int len, input bit empty_last);
        int nb;
        int total_beats;
        nb = (len + 7) / 8;
        total_beats = nb + (empty_last ? 1 : 0);
        for (int b = 0; b < total_beats; b++) begin
            int  n;
            int  wd;
            bit  ok;
            n = (b < nb) ? (((len - b*8) > 8) ? 8 : (len - b*8)) : 0;
            for (int i = 0; i < 8; i++) begin
                s_axis_tdata[i*8 +: 8] = (i < n) ? pay[b*8 + i] : 8'hee;
            end
            s_axis_tkeep  = count_to_keep(4'(n));
            s_axis_tlast  = (b == total_beats - 1);
            s_axis_tvalid = 1'b1;
            ok = 1'b0;
            wd = 0;
            while (!ok && wd < 200) begin
                @(negedge clk);
                ok = s_axis_tready;
                @(posedge clk);
                #1;
                wd++;
            end
            if (!ok) begin
                check("send_handshake_timeout", 64'(ok), 64'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Captures output beats until n_frames tlasts; checks hold-while-stalled.
    task automatic collect(input int n_frames, input bit toggle, input int max_cyc);
        int          frames;
        int          cyc;
        bit          snap_v;
        logic [63:0] snap_d;
        logic [8:0]  snap_kl;
        frames = 0;
        cyc    = 0;
        snap_v = 1'b0;
        snap_d = '0;
        snap_kl = '0;
        out_q.delete();
        keep_q.delete();
        last_q.delete();
        data_q.delete();
        cyc_q.delete();
        while (frames < n_frames && cyc < max_cyc) begin
            m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            if (snap_v) begin
                check("stall_valid_held", 64'(m_axis_tvalid), 64'd1);
                check("stall_data_held", m_axis_tdata, snap_d);
                check("stall_keep_last_held", 64'({m_axis_tkeep, m_axis_tlast}), 64'(snap_kl));
                snap_v = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_axis_tkeep[i]) out_q.push_back(m_axis_tdata[i*8 +: 8]);
                end
                keep_q.push_back(m_axis_tkeep);
                last_q.push_back(m_axis_tlast);
                data_q.push_back(m_axis_tdata);
                cyc_q.push_back(cyc);
                if (m_axis_tlast) frames++;
            end else if (m_axis_tvalid) begin
                snap_v  = 1'b1;
                snap_d  = m_axis_tdata;
                snap_kl = {m_axis_tkeep, m_axis_tlast};
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        m_axis_tready = 1'b1;
        check("collect_frames_done", 64'(frames), 64'(n_frames));
    endtask

    // Appends the expected wire bytes of one frame (header, payload, zero pad to 60).
    task automatic build_exp(input int len);
        int start;
        start = exp_q.size();
        for (int i = 5; i >= 0; i--) exp_q.push_back(exp_dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(exp_src[i*8 +: 8]);
        exp_q.push_back(exp_type[15:8]);
        exp_q.push_back(exp_type[7:0]);
        for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
        while (exp_q.size() - start < 60) exp_q.push_back(8'h00);
    endtask

    task automatic compare_stream(input string tag);
        int first_bad;
        int n;
        first_bad = -1;
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        check({tag, "_byte_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (first_bad < 0 && out_q[i] !== exp_q[i]) first_bad = i;
        end
        if (first_bad >= 0) begin
            check({tag, "_byte_at_first_diff"}, 64'(out_q[first_bad]), 64'(exp_q[first_bad]));
        end
        check({tag, "_first_diff_index"}, 64'(first_bad), 64'(-1));
    endtask

    task automatic check_beats(input string tag, input int n_beats, input logic [7:0] last_keep);
        bit full_ok;
        check({tag, "_beats"}, 64'(keep_q.size()), 64'(n_beats));
        check({tag, "_last_keep"}, 64'((keep_q.size() > 0) ? keep_q[keep_q.size()-1] : 8'h00),
              64'(last_keep));
        full_ok = 1'b1;
        for (int i = 0; i < keep_q.size(); i++) begin
            if (!last_q[i] && keep_q[i] !== 8'hff) full_ok = 1'b0;
        end
        check({tag, "_inner_keep_full"}, 64'(full_ok), 64'd1);
    endtask

    task automatic load_arp();
        logic [7:0] a [0:27];
        a = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
              8'hac, 8'h14, 8'h45, 8'hff, 8'haf, 8'hc4,
              8'hc0, 8'ha8, 8'h01, 8'h02,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hc0, 8'ha8, 8'h01, 8'h01};
        for (int i = 0; i < 28; i++) pay[i] = a[i];
        dst_mac_addr = 48'hffff_ffff_ffff;
        src_mac_addr = 48'hac14_45ff_afc4;
        eth_type     = ETH_TYPE_ARP;
        exp_dst      = 48'hffff_ffff_ffff;
        exp_src      = 48'hac14_45ff_afc4;
        exp_type     = 16'h0806;
        exp_q.delete();
        build_exp(28);
    endtask

    initial begin
        bit   any_valid;
        int   gap;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata", m_axis_tdata, 64'd0);
        check("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_frame_busy", 64'(frame_busy), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ARP request with continuous tready.
        load_arp();
        fork
            send_frame(28, 1'b0);
            collect(1, 1'b0, 200);
        join
        compare_stream("arp");
        check_beats("arp", 8, 8'h0f);
        check("arp_beat0_data", (data_q.size() > 0) ? data_q[0] : 64'd0, 64'h14ac_ffff_ffff_ffff);
        check("arp_beat1_data", (data_q.size() > 1) ? data_q[1] : 64'd0, 64'h0100_0608_c4af_ff45);
        check("arp_byte12", 64'((out_q.size() > 13) ? out_q[12] : 8'h00), 64'h08);
        check("arp_byte13", 64'((out_q.size() > 13) ? out_q[13] : 8'h00), 64'h06);
        check("arp_idle_busy", 64'(frame_busy), 64'd0);

        // Same ARP with tready toggling 1010...
        load_arp();
        fork
            send_frame(28, 1'b0);
            collect(1, 1'b1, 200);
        join
        compare_stream("arp_toggle");
        check_beats("arp_toggle", 8, 8'h0f);

        // 64-byte payload: 78 bytes, no padding.
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        exp_q.delete();
        build_exp(64);
        fork
            send_frame(64, 1'b0);
            collect(1, 1'b0, 200);
        join
        compare_stream("full64");
        check_beats("full64", 10, 8'h3f);

        // Single-beat payload with keep 0x01; addresses change mid-frame.
        pay[0] = 8'h5a;
        exp_q.delete();
        build_exp(1);
        fork
            send_frame(1, 1'b0);
            collect(1, 1'b0, 200);
            begin
                @(posedge clk);
                #2;
                dst_mac_addr = 48'h0102_0304_0506;
                src_mac_addr = 48'h1112_1314_1516;
                eth_type     = ETH_TYPE_IPV4;
            end
        join
        compare_stream("one_byte");
        check_beats("one_byte", 8, 8'h0f);
        check("one_byte_beat1_data", (data_q.size() > 1) ? data_q[1] : 64'd0, 64'h005a_0608_c4af_ff45);

        // Two full beats then a tlast beat with keep 0.
        load_arp();
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'h30 + i);
        exp_q.delete();
        build_exp(16);
        fork
            send_frame(16, 1'b1);
            collect(1, 1'b0, 200);
        join
        compare_stream("empty_last");
        check_beats("empty_last", 8, 8'h0f);

        // Reset asserted while in BODY of a long frame.
        s_axis_tdata  = 64'h0706_0504_0302_0100;
        s_axis_tkeep  = 8'hff;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", 64'(frame_busy), 64'd1);
        check("midrst_valid_before", 64'(m_axis_tvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_m_tdata", m_axis_tdata, 64'd0);
        check("midrst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("midrst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        check("midrst_frame_busy", 64'(frame_busy), 64'd0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        any_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            any_valid = any_valid | m_axis_tvalid;
            @(posedge clk);
            #1;
        end
        check("post_reset_no_output", 64'(any_valid), 64'd0);
        load_arp();
        fork
            send_frame(28, 1'b0);
            collect(1, 1'b0, 200);
        join
        compare_stream("after_reset");
        check_beats("after_reset", 8, 8'h0f);

        // Two ARP frames back-to-back with s_axis_tvalid held high.
        load_arp();
        build_exp(28);
        fork
            begin
                send_frame(28, 1'b0);
                send_frame(28, 1'b0);
            end
            collect(2, 1'b0, 400);
        join
        compare_stream("b2b");
        check("b2b_beats", 64'(keep_q.size()), 64'd16);
        gap = (cyc_q.size() > 8) ? (cyc_q[8] - cyc_q[7]) : 99;
        check("b2b_gap_at_most_one_idle", 64'(gap <= 2), 64'd1);
        check("b2b_first_last_pos", 64'((last_q.size() > 7) ? last_q[7] : 1'b0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
